// File: rtl/imem_fetch_ctrl_pkg.sv
// Shared definitions for the instruction fetch controller: widths, timeout and FSM encoding.
package imem_fetch_ctrl_pkg;

  localparam int unsigned ADDR_W_DEF  = 24;
  localparam int unsigned INS_W_DEF   = 32;
  localparam int unsigned TIMEOUT_DEF = 15;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } fetch_state_e;

endpackage

// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: one IMEM read per instruction, IR hold until decode
// accepts it, PC advance pulse, flush/redirect drain and sticky IMEM timeout flag.
module imem_fetch_ctrl
  import imem_fetch_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter int unsigned INS_W   = INS_W_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              flush,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_inc,
  output logic [ADDR_W-1:0] imem_addr,
  output logic              imem_rd,
  input  logic              imem_ready,
  input  logic [INS_W-1:0]  imem_data,
  output logic [INS_W-1:0]  ir,
  output logic              ir_valid,
  input  logic              ir_accept,
  output logic              fetch_err
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  fetch_state_e      state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [ADDR_W-1:0] imem_addr_nxt;
  logic              imem_rd_nxt;
  logic [INS_W-1:0]  ir_nxt;
  logic              ir_valid_nxt;
  logic              fetch_err_nxt;
  logic              timeout_hit;

  // Request outstanding with no response and the budget spent
  assign timeout_hit = !imem_ready && (cnt == CNT_W'(TIMEOUT));

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (fetch_en) state_nxt = ST_ISSUE;
      ST_ISSUE: begin
        if (!fetch_en)   state_nxt = ST_IDLE;
        else if (!flush) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_ready)       state_nxt = flush ? ST_ISSUE : ST_HOLD;
        else if (flush)       state_nxt = ST_DRAIN;
        else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_DRAIN: begin
        if (imem_ready)       state_nxt = ST_ISSUE;
        else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_HOLD: begin
        if (flush)          state_nxt = ST_ISSUE;
        else if (ir_accept) state_nxt = fetch_en ? ST_ISSUE : ST_IDLE;
      end
      default:              state_nxt = ST_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs plus the pc_inc strobe
  always_comb begin
    imem_addr_nxt = imem_addr;
    imem_rd_nxt   = imem_rd;
    ir_nxt        = ir;
    ir_valid_nxt  = ir_valid;
    fetch_err_nxt = fetch_err;
    cnt_nxt       = cnt;
    pc_inc        = (state == ST_HOLD) && ir_accept && !flush && !reset;
    case (state)
      ST_ISSUE: begin
        if (fetch_en && !flush) begin
          imem_addr_nxt = pc_addr;
          imem_rd_nxt   = 1'b1;
          cnt_nxt       = '0;
        end
      end
      ST_WAIT: begin
        if (imem_ready) begin
          imem_rd_nxt = 1'b0;
          if (!flush) begin
            ir_nxt       = imem_data;
            ir_valid_nxt = 1'b1;
          end
        end else if (!flush) begin
          if (timeout_hit) begin
            fetch_err_nxt = 1'b1;
            imem_rd_nxt   = 1'b0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      ST_DRAIN: begin
        // Response to the abandoned request is discarded
        if (imem_ready) begin
          imem_rd_nxt = 1'b0;
        end else if (timeout_hit) begin
          fetch_err_nxt = 1'b1;
          imem_rd_nxt   = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (flush || ir_accept) ir_valid_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_addr <= '0;
      imem_rd   <= 1'b0;
      ir        <= '0;
      ir_valid  <= 1'b0;
      fetch_err <= 1'b0;
      cnt       <= '0;
    end else begin
      imem_addr <= imem_addr_nxt;
      imem_rd   <= imem_rd_nxt;
      ir        <= ir_nxt;
      ir_valid  <= ir_valid_nxt;
      fetch_err <= fetch_err_nxt;
      cnt       <= cnt_nxt;
    end
  end

endmodule
